class_vote_decider: RTL and testbench

- Sits directly downstream of the softmax stage and consumes its flattened 4-class probability vector (Q2.14, unsigned) plus its valid strobe.
- For each frame, finds the argmax and checks it against a confidence threshold.
- Pushes confident decisions into a circular history and majority-votes over that history.
- Drives the final class, the confidence value, a one-cycle result strobe and the board LEDs, giving a temporally stable diagnosis instead of a per-frame flicker.

---
 rtl/class_vote_decider_pkg.sv | 36 +++
 rtl/class_vote_decider_hist_vote_counter.sv | 90 +++++++++
 rtl/class_vote_decider.sv | 155 +++++++++++++++
 tb/tb_class_vote_decider.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/class_vote_decider_pkg.sv
// -----------------------------------------------------------------------------
// class_vote_decider_pkg
//   Shared definitions for the class vote decider:
//     - class index width
//     - Q2.14 probability constants (unity and default confidence threshold)
//     - controller state encoding
//     - one-hot LED mapping helper
// -----------------------------------------------------------------------------
package class_vote_decider_pkg;

  // Class index width for the 4-class classifier.
  localparam int unsigned CLASS_W = 2;

  // Q2.14 unsigned: 1.0 == 16'h4000.
  localparam logic [15:0] Q_ONE               = 16'h4000;
  // 0.5 in Q2.14 -- a frame must reach this to enter the history.
  localparam logic [15:0] CONF_THRESH_DEFAULT = Q_ONE >> 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_CHECK = 2'd2,
    ST_VOTE  = 2'd3
  } state_t;

  // Board LEDs: [3:0] one-hot class, [6:4] unused, [7] low-confidence flag.
  function automatic logic [7:0] led_map(input logic [CLASS_W-1:0] cls,
                                         input logic               low);
    logic [7:0] led;
    led      = '0;
    led[cls] = 1'b1;
    led[7]   = low;
    return led;
  endfunction

endpackage

// File: rtl/class_vote_decider_hist_vote_counter.sv
// -----------------------------------------------------------------------------
// hist_vote_counter
//   Circular history of confident class decisions plus a combinational
//   majority vote over the valid entries.
//
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     clear           synchronous flush (count and pointer to 0)
//     push            write push_class at the write pointer
//     push_class      class index to record
//     fallback_class  winner reported while the history is empty
//     count           number of valid entries (0..HIST_DEPTH)
//     winner          most frequent class; ties go to the lower index
// -----------------------------------------------------------------------------
module hist_vote_counter
  import class_vote_decider_pkg::*;
#(
  parameter int unsigned NUM_CLASSES = 4,
  parameter int unsigned HIST_DEPTH  = 8,
  parameter int unsigned HIST_PTR_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [CLASS_W-1:0]    push_class,
  input  logic [CLASS_W-1:0]    fallback_class,
  output logic [HIST_PTR_W:0]   count,
  output logic [CLASS_W-1:0]    winner
);

  localparam logic [HIST_PTR_W:0] FULL = (HIST_PTR_W+1)'(HIST_DEPTH);

  logic [CLASS_W-1:0]    entries [HIST_DEPTH];
  logic [HIST_PTR_W-1:0] wr_ptr;
  logic [HIST_PTR_W:0]   class_count [NUM_CLASSES];
  logic [CLASS_W-1:0]    best_idx;
  logic [HIST_PTR_W:0]   best_cnt;

  // A clear coinciding with a push restarts the history with that single
  // entry: it lands in slot 0 and the pointer moves on to slot 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (push) begin
        entries[clear ? '0 : wr_ptr] <= push_class;
      end
      if (clear) begin
        wr_ptr <= push ? HIST_PTR_W'(1) : '0;
        count  <= push ? (HIST_PTR_W+1)'(1) : '0;
      end else if (push) begin
        wr_ptr <= wr_ptr + HIST_PTR_W'(1);
        if (count != FULL) begin
          count <= count + (HIST_PTR_W+1)'(1);
        end
      end
    end
  end

  // Until the buffer fills, valid entries are exactly slots 0..count-1;
  // once full every slot is valid, so "index < count" covers both cases.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
      class_count[k] = '0;
    end
    for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
      if ((HIST_PTR_W+1)'(i) < count) begin
        class_count[entries[i]] = class_count[entries[i]] + (HIST_PTR_W+1)'(1);
      end
    end
  end

  always_comb begin
    best_idx = '0;
    best_cnt = class_count[0];
    for (int unsigned k = 1; k < NUM_CLASSES; k++) begin
      if (class_count[k] > best_cnt) begin
        best_idx = CLASS_W'(k);
        best_cnt = class_count[k];
      end
    end
    winner = (count == '0) ? fallback_class : best_idx;
  end

endmodule

// File: rtl/class_vote_decider.sv
// -----------------------------------------------------------------------------
// class_vote_decider
//   Per-frame argmax over a 4-class Q2.14 probability vector, confidence
//   gating, and majority vote over a short history of confident frames.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     in             flattened probabilities, class k in [16k+15:16k]
//     in_valid       frame present (accepted only while in_ready)
//     in_ready       high only while idle
//     hist_clear     synchronous history flush, honoured in any state
//     class_out      voted class
//     confidence     winning probability of the current frame
//     low_conf       current frame fell below CONF_THRESH
//     result_valid   one-cycle strobe when the outputs update
//     hist_count     valid history entries at the last result
//     led_control    [3:0] one-hot class_out, [7] low_conf, [6:4] zero
// -----------------------------------------------------------------------------
module class_vote_decider
  import class_vote_decider_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           NUM_CLASSES = 4,
  parameter int unsigned           HIST_DEPTH  = 8,
  parameter int unsigned           HIST_PTR_W  = 3,
  parameter logic [DATA_WIDTH-1:0] CONF_THRESH = CONF_THRESH_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] in,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              hist_clear,
  output logic [CLASS_W-1:0]                class_out,
  output logic [DATA_WIDTH-1:0]             confidence,
  output logic                              low_conf,
  output logic                              result_valid,
  output logic [HIST_PTR_W:0]               hist_count,
  output logic [7:0]                        led_control
);

  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] frame_q [NUM_CLASSES];
  logic [DATA_WIDTH-1:0] max_val;
  logic [CLASS_W-1:0]    max_idx;
  logic [CLASS_W-1:0]    scan_idx;
  logic                  frame_low;
  logic                  hist_push;
  logic [HIST_PTR_W:0]   live_count;
  logic [CLASS_W-1:0]    vote_winner;

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hist_push = 1'b0;
    unique case (state)
      ST_IDLE:  if (in_valid) state_nxt = ST_SCAN;
      ST_SCAN:  if (scan_idx == LAST_IDX) state_nxt = ST_CHECK;
      ST_CHECK: begin
        hist_push = (max_val >= CONF_THRESH);
        state_nxt = ST_VOTE;
      end
      ST_VOTE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_IDLE);

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        frame_q[k] <= '0;
      end
      max_val      <= '0;
      max_idx      <= '0;
      scan_idx     <= '0;
      frame_low    <= 1'b0;
      class_out    <= '0;
      confidence   <= '0;
      low_conf     <= 1'b0;
      result_valid <= 1'b0;
      hist_count   <= '0;
      led_control  <= '0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
              frame_q[k] <= in[k*DATA_WIDTH +: DATA_WIDTH];
            end
            max_val  <= in[DATA_WIDTH-1:0];
            max_idx  <= '0;
            scan_idx <= CLASS_W'(1);
          end
        end
        ST_SCAN: begin
          // Strictly greater keeps the lower index on ties.
          if (frame_q[scan_idx] > max_val) begin
            max_val <= frame_q[scan_idx];
            max_idx <= scan_idx;
          end
          scan_idx <= scan_idx + CLASS_W'(1);
        end
        ST_CHECK: begin
          frame_low <= ~hist_push;
        end
        ST_VOTE: begin
          class_out    <= vote_winner;
          confidence   <= max_val;
          low_conf     <= frame_low;
          led_control  <= led_map(vote_winner, frame_low);
          hist_count   <= live_count;
          result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // History and vote
  // ---------------------------------------------------------------------------
  hist_vote_counter #(
    .NUM_CLASSES (NUM_CLASSES),
    .HIST_DEPTH  (HIST_DEPTH),
    .HIST_PTR_W  (HIST_PTR_W)
  ) u_hist (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (hist_clear),
    .push           (hist_push),
    .push_class     (max_idx),
    .fallback_class (max_idx),
    .count          (live_count),
    .winner         (vote_winner)
  );

endmodule

// File: tb/tb_class_vote_decider.sv
module tb_class_vote_decider;

  typedef struct {
    logic [1:0]  cls;
    logic [15:0] conf;
    logic        low;
    logic [3:0]  cnt;
    logic [7:0]  led;
  } exp_t;

  typedef struct {
    logic [63:0] data;
    bit          pre_clr;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        hist_clear;
  logic [1:0]  class_out;
  logic [15:0] confidence;
  logic        low_conf;
  logic        result_valid;
  logic [3:0]  hist_count;
  logic [7:0]  led_control;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  // Reference history model
  int m_hist[8];
  int m_ptr = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  class_vote_decider #(
    .DATA_WIDTH  (16),
    .NUM_CLASSES (4),
    .HIST_DEPTH  (8),
    .HIST_PTR_W  (3),
    .CONF_THRESH (16'h2000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .hist_clear   (hist_clear),
    .class_out    (class_out),
    .confidence   (confidence),
    .low_conf     (low_conf),
    .result_valid (result_valid),
    .hist_count   (hist_count),
    .led_control  (led_control)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void model_clear();
    m_cnt = 0;
    m_ptr = 0;
  endfunction

  function automatic exp_t model(input logic [63:0] d, input bit clr);
    exp_t        r;
    logic [15:0] mv;
    logic [15:0] v;
    int          mi;
    int          votes[4];
    int          w;
    mv = d[15:0];
    mi = 0;
    for (int k = 1; k < 4; k++) begin
      v = d[16*k +: 16];
      if (v > mv) begin
        mv = v;
        mi = k;
      end
    end
    if (clr) model_clear();
    if (mv >= 16'h2000) begin
      m_hist[m_ptr] = mi;
      m_ptr = (m_ptr + 1) % 8;
      if (m_cnt < 8) m_cnt++;
    end
    for (int k = 0; k < 4; k++) votes[k] = 0;
    for (int i = 0; i < m_cnt; i++) votes[m_hist[i]]++;
    w = 0;
    for (int k = 1; k < 4; k++) if (votes[k] > votes[w]) w = k;
    if (m_cnt == 0) w = mi;
    r.cls  = 2'(w);
    r.conf = mv;
    r.low  = (mv < 16'h2000);
    r.cnt  = 4'(m_cnt);
    r.led  = 8'(1 << w) | (r.low ? 8'h80 : 8'h00);
    return r;
  endfunction

  // Scoreboard monitor: every strobe must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got strobe class %0h, expected no strobe", class_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("class_out",   class_out,   e.cls);
        check("confidence",  confidence,  e.conf);
        check("low_conf",    low_conf,    e.low);
        check("hist_count",  hist_count,  e.cnt);
        check("led_control", led_control, e.led);
      end
    end
  end

  task automatic pulse_clear();
    hist_clear = 1'b1;
    @(negedge clk);
    hist_clear = 1'b0;
    model_clear();
  endtask

  // Drive one frame and follow it to its result. clr_chk raises hist_clear in
  // the CHECK cycle; inject offers a second frame while the block is busy.
  task automatic send(input logic [63:0] d, input bit clr_chk, input bit inject, input exp_t e);
    int k;
    bit got;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_send", in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 0);
    k   = 1;
    got = 1'b0;
    while (k <= 20 && !got) begin
      hist_clear = clr_chk && (k == 4);
      if (inject && k == 2) begin
        in_data  = ~d;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (result_valid) got = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    hist_clear = 1'b0;
    in_valid   = 1'b0;
    check("result_latency", got ? k : 99, 6);
    @(negedge clk);
    check("strobe_width", result_valid, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [63:0] d;
    vecs[0] = '{64'h0400_0800_3000_0400, 1'b0, '{2'd1, 16'h3000, 1'b0, 4'd1, 8'h02}};
    vecs[1] = '{64'h0000_3800_0400_0400, 1'b1, '{2'd2, 16'h3800, 1'b0, 4'd1, 8'h04}};
    vecs[2] = '{64'h0100_2800_0000_1000, 1'b0, '{2'd2, 16'h2800, 1'b0, 4'd2, 8'h04}};
    vecs[3] = '{64'h0000_0400_2000_0100, 1'b0, '{2'd2, 16'h2000, 1'b0, 4'd3, 8'h04}};
    vecs[4] = '{64'h1000_1000_1000_1000, 1'b1, '{2'd0, 16'h1000, 1'b1, 4'd0, 8'h81}};
    vecs[5] = '{64'h1FFF_0000_0000_0000, 1'b0, '{2'd3, 16'h1FFF, 1'b1, 4'd0, 8'h88}};
    vecs[6] = '{64'h3000_3000_0000_0000, 1'b0, '{2'd2, 16'h3000, 1'b0, 4'd1, 8'h04}};

    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    hist_clear = 1'b0;
    #1;
    check("reset_in_ready",     in_ready,     1);
    check("reset_class_out",    class_out,    0);
    check("reset_confidence",   confidence,   0);
    check("reset_result_valid", result_valid, 0);
    check("reset_hist_count",   hist_count,   0);
    check("reset_led",          led_control,  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      exp_t unused_e;
      if (vecs[i].pre_clr) pulse_clear();
      unused_e = model(vecs[i].data, 1'b0);
      send(vecs[i].data, 1'b0, 1'b0, vecs[i].e);
    end

    // Saturation and pointer wrap: 10 x class 3 then 5 x class 0.
    pulse_clear();
    for (int i = 0; i < 10; i++) begin
      d = 64'h3000_0400_0400_0400 + 64'(i) * 64'h0010_0000_0000_0000;
      send(d, 1'b0, 1'b0, model(d, 1'b0));
    end
    for (int i = 0; i < 5; i++) begin
      d = 64'h0400_0400_0400_2800 + 64'(i);
      send(d, 1'b0, 1'b0, model(d, 1'b0));
    end
    check("saturated_count", hist_count, 8);
    check("wrap_vote",       class_out,  0);

    // 4-4 split between classes 3 and 1 resolves to the lower index.
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      d = 64'h3000_0000_0000_0000;
      send(d, 1'b0, 1'b0, model(d, 1'b0));
    end
    for (int i = 0; i < 4; i++) begin
      d = 64'h0000_0000_2400_0000;
      send(d, 1'b0, 1'b0, model(d, 1'b0));
    end
    check("tie_vote", class_out, 1);

    // Frame offered during SCAN must be dropped.
    d = 64'h0000_3A00_0000_0100;
    send(d, 1'b0, 1'b1, model(d, 1'b0));

    // hist_clear coincident with a CHECK push.
    d = 64'h2200_0000_0100_0000;
    send(d, 1'b1, 1'b0, model(d, 1'b1));
    check("clear_push_count", hist_count, 1);
    check("clear_push_class", class_out,  3);

    // Reset while scanning: outputs clear at once, no strobe follows.
    in_data  = 64'h0000_0000_3000_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready",   in_ready,    1);
    check("midreset_class_out",  class_out,   0);
    check("midreset_confidence", confidence,  0);
    check("midreset_hist_count", hist_count,  0);
    check("midreset_led",        led_control, 0);
    check("midreset_low_conf",   low_conf,    0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 8; i++) @(negedge clk);

    // History is empty after reset.
    d = 64'h0000_0000_1800_0000;
    send(d, 1'b0, 1'b0, model(d, 1'b0));

    for (int i = 0; i < 4; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
